// File: rtl/shifter_right_seq.sv
// Multi-cycle 32-bit right shifter (SRL/SRA), one power-of-two stage per clock.
// Fixed 6-cycle start-to-done latency; start is ignored while busy or in the done cycle.
module shifter_right_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dataA,
    input  logic [4:0]  dataB,
    input  logic        arith,
    output logic        busy,
    output logic        done,
    output logic [31:0] dataOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  amt_q, amt_d;
    logic        fill_q, fill_d;
    logic [2:0]  stage_q, stage_d;
    logic [31:0] data_out_q, data_out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] stage_res;

    // Result of the current stage: shift by 2^stage when that amount bit is set.
    always_comb begin
        stage_res = acc_q;
        case (stage_q)
            3'd0: if (amt_q[0]) stage_res = {fill_q, acc_q[31:1]};
            3'd1: if (amt_q[1]) stage_res = {{2{fill_q}}, acc_q[31:2]};
            3'd2: if (amt_q[2]) stage_res = {{4{fill_q}}, acc_q[31:4]};
            3'd3: if (amt_q[3]) stage_res = {{8{fill_q}}, acc_q[31:8]};
            3'd4: if (amt_q[4]) stage_res = {{16{fill_q}}, acc_q[31:16]};
            default: stage_res = acc_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        amt_d      = amt_q;
        fill_d     = fill_q;
        stage_d    = stage_q;
        data_out_d = data_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = dataA;
                    amt_d   = dataB;
                    fill_d  = arith & dataA[31];
                    stage_d = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = stage_res;
                stage_d = stage_q + 3'd1;
                if (stage_q == 3'd4) begin
                    state_d    = DONE;
                    data_out_d = stage_res;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status outputs are registered from the next state so they leave flops directly.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            amt_q      <= '0;
            fill_q     <= 1'b0;
            stage_q    <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            amt_q      <= amt_d;
            fill_q     <= fill_d;
            stage_q    <= stage_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign dataOut = data_out_q;

endmodule

// File: tb/tb_shifter_right_seq.sv
// Directed and swept checks of shifter_right_seq: latency, handshake, reset, results.
module tb_shifter_right_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dataA;
    logic [4:0]  dataB;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] dataOut;

    int n_chk = 0;
    int n_err = 0;

    shifter_right_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dataA   (dataA),
        .dataB   (dataB),
        .arith   (arith),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  b;
        logic        ar;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] b, input logic ar);
        if (ar) return $signed(a) >>> b;
        return a >> b;
    endfunction

    // Called at a negedge while IDLE: that cycle is cycle 0 of the operation.
    task automatic run_op(input logic [31:0] a, input logic [4:0] b, input logic ar,
                          input logic [31:0] exp, input string name);
        chk({name, ".busy0"}, {31'd0, busy}, 32'd0);
        start = 1'b1;
        dataA = a;
        dataB = b;
        arith = ar;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            dataA = ~a;
            dataB = ~b;
            arith = ~ar;
            chk($sformatf("%s.busy%0d", name, c), {31'd0, busy}, {31'd0, (c <= 6)});
            chk($sformatf("%s.done%0d", name, c), {31'd0, done}, {31'd0, (c == 6)});
            if (c >= 6) chk($sformatf("%s.out%0d", name, c), dataOut, exp);
        end
    endtask

    initial begin
        logic [31:0] ra;
        int          n_done;

        vecs[0] = '{32'h8000_00F0, 5'd4,  1'b0, 32'h0800_000F};
        vecs[1] = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF};
        vecs[2] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};
        vecs[3] = '{32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678};
        vecs[4] = '{32'h1234_5678, 5'd13, 1'b1, 32'h0000_91A2};
        vecs[5] = '{32'hF000_0000, 5'd4,  1'b1, 32'hFF00_0000};
        vecs[6] = '{32'h8765_4321, 5'd16, 1'b0, 32'h0000_8765};
        vecs[7] = '{32'h8765_4321, 5'd16, 1'b1, 32'hFFFF_8765};
        vecs[8] = '{32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000};
        vecs[9] = '{32'hA5A5_A5A5, 5'd7,  1'b0, 32'h014B_4B4B};

        rst   = 1'b1;
        start = 1'b0;
        dataA = '0;
        dataB = '0;
        arith = 1'b0;
        @(negedge clk);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.out", dataOut, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].ar, vecs[i].exp, $sformatf("vec%0d", i));

        // Extra starts in cycles 2 and 6 must be ignored.
        n_done = 0;
        start = 1'b1; dataA = 32'hC000_0000; dataB = 5'd1; arith = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done) n_done++;
            start = (c == 2) || (c == 6);
            dataA = 32'h0000_FFFF;
        end
        chk("ignore.ndone", n_done, 32'd1);
        chk("ignore.out", dataOut, 32'hE000_0000);
        chk("ignore.busy", {31'd0, busy}, 32'd0);

        // Held start: accepts at cycles 0, 7, 14 with the inputs of those cycles.
        for (int c = 0; c <= 22; c++) begin
            logic [31:0] e0, e7, e14;
            e0  = model(32'h0101_0101 * 0,  5'd8, 1'b1);
            e7  = model(32'h0101_0101 * 7,  5'd8, 1'b1);
            e14 = model(32'h0101_0101 * 14, 5'd8, 1'b1);
            if (c > 0) @(negedge clk);
            chk($sformatf("held.done%0d", c), {31'd0, done}, {31'd0, (c == 6 || c == 13 || c == 20)});
            if (c == 0 || c == 7 || c == 14)
                chk($sformatf("held.busy%0d", c), {31'd0, busy}, 32'd0);
            if (c >= 6 && c <= 12)  chk($sformatf("held.out%0d", c), dataOut, e0);
            if (c >= 13 && c <= 19) chk($sformatf("held.out%0d", c), dataOut, e7);
            if (c >= 20)            chk($sformatf("held.out%0d", c), dataOut, e14);
            start = (c < 20);
            dataA = 32'h0101_0101 * c;
            dataB = 5'd8;
            arith = 1'b1;
        end

        // Reset in cycle 3 of an operation, with start also high.
        start = 1'b1; dataA = 32'hDEAD_BEEF; dataB = 5'd3; arith = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 4) begin
                chk("rstmid.busy", {31'd0, busy}, 32'd0);
                chk("rstmid.out", dataOut, 32'd0);
            end
            if (c >= 4) chk($sformatf("rstmid.done%0d", c), {31'd0, done}, 32'd0);
            rst   = (c == 3);
            start = (c == 3);
        end
        run_op(32'hDEAD_BEEF, 5'd3, 1'b0, 32'h1BD5_B7DD, "after_rst");

        // Sweep every amount, both modes, against the reference model.
        for (int b = 0; b < 32; b++) begin
            for (int m = 0; m < 2; m++) begin
                ra = $urandom;
                if (b[0]) ra[31] = 1'b1;
                run_op(ra, b[4:0], m[0], model(ra, b[4:0], m[0]), $sformatf("sweep_b%0d_m%0d", b, m));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
